// File: rtl/nbr_addr_gen.sv
// nbr_addr_gen: streams (2R+1)^2 neighbourhood addresses around an event, LANES per beat.
// Define NBR_SKIP_CENTER_EN to drop the centre point from the sequence.
module nbr_addr_gen #(
  parameter int CAVIAR_X_Y_BITS = 9,
  parameter int PATCH_RADIUS    = 2,
  parameter int LANES           = 2,
  parameter int SENSOR_W        = 128,
  parameter int SENSOR_H        = 128
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [CAVIAR_X_Y_BITS-1:0]         in_x,
  input  logic [CAVIAR_X_Y_BITS-1:0]         in_y,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [LANES*CAVIAR_X_Y_BITS-1:0]   out_x,
  output logic [LANES*CAVIAR_X_Y_BITS-1:0]   out_y,
  output logic [LANES-1:0]                   out_lane_valid,
  output logic                               out_last,
  output logic [7:0]                         out_beat
);
  localparam int B = CAVIAR_X_Y_BITS;
  localparam int S = 2*PATCH_RADIUS+1;
  localparam int C = S*PATCH_RADIUS + PATCH_RADIUS;
`ifdef NBR_SKIP_CENTER_EN
  localparam bit SKIP = 1'b1;
  localparam int N = S*S-1;
`else
  localparam bit SKIP = 1'b0;
  localparam int N = S*S;
`endif
  localparam int BEATS = (N+LANES-1)/LANES;
  localparam logic [7:0] LAST = 8'(BEATS-1);

  if (PATCH_RADIUS < 1 || PATCH_RADIUS > 7) begin : g_bad_radius
    $error("PATCH_RADIUS out of range 1..7");
  end
  if (LANES < 1 || LANES > 8) begin : g_bad_lanes
    $error("LANES out of range 1..8");
  end
  if (BEATS > 255) begin : g_bad_beats
    $error("BEATS exceeds 255");
  end

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [7:0] beat, beat_n;
  logic [B-1:0] lx, ly, lx_n, ly_n;
  logic run;
  int p, q, xs, ys;

  assign run       = state == RUN;
  assign out_valid = run;
  assign out_last  = run && beat == LAST;
  assign in_ready  = !run || (out_last && out_ready);
  assign out_beat  = beat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      beat  <= '0;
      lx    <= '0;
      ly    <= '0;
    end else begin
      state <= state_n;
      beat  <= beat_n;
      lx    <= lx_n;
      ly    <= ly_n;
    end
  end

  always_comb begin
    state_n = state;
    beat_n  = beat;
    lx_n    = lx;
    ly_n    = ly;
    if (in_valid && in_ready) begin
      state_n = RUN;
      beat_n  = '0;
      lx_n    = in_x;
      ly_n    = in_y;
    end else if (run && out_ready) begin
      state_n = out_last ? IDLE : RUN;
      beat_n  = out_last ? 8'd0 : beat + 8'd1;
    end
  end

  // sequence index -> physical point (skipping the centre when enabled) -> bounds check
  always_comb begin
    out_x          = '0;
    out_y          = '0;
    out_lane_valid = '0;
    p  = 0;
    q  = 0;
    xs = 0;
    ys = 0;
    for (int l = 0; l < LANES; l++) begin
      p  = int'(beat)*LANES + l;
      q  = (SKIP && p >= C) ? p+1 : p;
      xs = int'(lx) + q % S - PATCH_RADIUS;
      ys = int'(ly) + q / S - PATCH_RADIUS;
      if (run && p < N && xs >= 0 && xs < SENSOR_W && ys >= 0 && ys < SENSOR_H) begin
        out_lane_valid[l] = 1'b1;
        out_x[l*B +: B]   = xs[B-1:0];
        out_y[l*B +: B]   = ys[B-1:0];
      end
    end
  end
endmodule

// File: tb/tb_nbr_addr_gen.sv
// tb_nbr_addr_gen: directed and randomized checks of nbr_addr_gen against a patch-list model.
module tb_nbr_addr_gen;
  localparam int B = 9, R = 2, L = 2, W = 128, H = 128;
  typedef struct {bit v; int x; int y;} pt_t;
  typedef pt_t pq_t[$];

  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [B-1:0] in_x = '0, in_y = '0;
  logic in_ready, out_valid, out_last;
  logic [L*B-1:0] out_x, out_y;
  logic [L-1:0] out_lane_valid;
  logic [7:0] out_beat;
  int nvec = 0, nerr = 0;

  nbr_addr_gen #(.CAVIAR_X_Y_BITS(B), .PATCH_RADIUS(R), .LANES(L), .SENSOR_W(W), .SENSOR_H(H)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
    .out_lane_valid(out_lane_valid), .out_last(out_last), .out_beat(out_beat)
  );

  always #5 clk = ~clk;

  function automatic pq_t patch(input int x, input int y);
    pq_t q;
    for (int dy = -R; dy <= R; dy++)
      for (int dx = -R; dx <= R; dx++) begin
`ifdef NBR_SKIP_CENTER_EN
        if (dx == 0 && dy == 0) continue;
`endif
        q.push_back('{x+dx >= 0 && x+dx < W && y+dy >= 0 && y+dy < H, x+dx, y+dy});
      end
    return q;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input pq_t q, input int b);
    logic [L*B-1:0] ex = '0, ey = '0;
    logic [L-1:0] ev = '0;
    int nb = (q.size()+L-1)/L;
    for (int l = 0; l < L; l++) begin
      int i = b*L + l;
      if (i < q.size() && q[i].v) begin
        ev[l] = 1'b1;
        ex[l*B +: B] = B'(q[i].x);
        ey[l*B +: B] = B'(q[i].y);
      end
    end
    chk($sformatf("beat%0d out_valid", b), out_valid, 1);
    chk($sformatf("beat%0d out_beat", b), out_beat, b);
    chk($sformatf("beat%0d out_x", b), out_x, ex);
    chk($sformatf("beat%0d out_y", b), out_y, ey);
    chk($sformatf("beat%0d lane_valid", b), out_lane_valid, ev);
    chk($sformatf("beat%0d out_last", b), out_last, b == nb-1);
    chk($sformatf("beat%0d in_ready", b), in_ready, (b == nb-1) && out_ready);
  endtask

  task automatic idle_chk(input string tag);
    #1;
    chk({tag, " out_valid"}, out_valid, 0);
    chk({tag, " out_last"}, out_last, 0);
    chk({tag, " lane_valid"}, out_lane_valid, 0);
    chk({tag, " out_x"}, out_x, 0);
    chk({tag, " out_y"}, out_y, 0);
    chk({tag, " in_ready"}, in_ready, 1);
  endtask

  task automatic start(input int x, input int y);
    @(negedge clk);
    in_valid = 1;
    in_x = B'(x);
    in_y = B'(y);
    #1 chk("start in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 0;
  endtask

  // Consumes one patch; sb selects a beat stalled for 5 cycles, chain presents the next event on the last beat
  task automatic drain(input int x, input int y, input int max_stall, input int sb,
                       input bit chain, input int nx, input int ny);
    pq_t q = patch(x, y);
    int nb = (q.size()+L-1)/L;
    for (int b = 0; b < nb; b++) begin
      int st = (b == sb) ? 5 : (max_stall > 0 ? int'($urandom_range(0, max_stall)) : 0);
      out_ready = 0;
      repeat (st) begin
        in_x = B'($urandom);
        in_y = B'($urandom);
        #1 chk_beat(q, b);
        @(negedge clk);
      end
      out_ready = 1;
      if (b == nb-1 && chain) begin
        in_valid = 1;
        in_x = B'(nx);
        in_y = B'(ny);
      end else begin
        in_x = B'($urandom);
        in_y = B'($urandom);
      end
      #1 chk_beat(q, b);
      @(negedge clk);
      in_valid = 0;
    end
  endtask

  initial begin
    int cx, cy, nx, ny;
    bit ch;
    repeat (2) @(negedge clk);
    idle_chk("reset");
    chk("reset out_beat", out_beat, 0);
    rst = 0;
    out_ready = 1;

    start(10, 20);
    #1;
    chk("t1 beat0 x", out_x, {9'd9, 9'd8});
    chk("t1 beat0 y", out_y, {9'd18, 9'd18});
    chk("t1 beat0 lanes", out_lane_valid, 2'b11);
    drain(10, 20, 0, -1, 0, 0, 0);
    idle_chk("t1 end");

    start(0, 0);
    #1 chk("t2 corner lanes", out_lane_valid, 2'b00);
    drain(0, 0, 0, -1, 0, 0, 0);
    idle_chk("t2 end");
    start(127, 127);
    drain(127, 127, 0, -1, 0, 0, 0);
    idle_chk("t2b end");

    start(10, 20);
    drain(10, 20, 0, 3, 0, 0, 0);
    idle_chk("t3 end");

    start(10, 20);
    drain(10, 20, 0, -1, 1, 50, 60);
    #1;
    chk("t4 b2b x", out_x, {9'd49, 9'd48});
    chk("t4 b2b y", out_y, {9'd58, 9'd58});
    chk("t4 b2b beat", out_beat, 0);
    drain(50, 60, 0, -1, 0, 0, 0);
    idle_chk("t4 end");

    start(10, 20);
    out_ready = 1;
    repeat (5) @(negedge clk);
    #1 chk("t5 beat before rst", out_beat, 5);
    rst = 1;
    idle_chk("t5 in rst");
    chk("t5 rst beat", out_beat, 0);
    @(negedge clk);
    rst = 0;
    idle_chk("t5 after rst");
    start(10, 20);
    drain(10, 20, 0, -1, 0, 0, 0);
    idle_chk("t5 end");

    cx = $urandom_range(0, 140);
    cy = $urandom_range(0, 140);
    start(cx, cy);
    for (int i = 0; i < 25; i++) begin
      nx = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 511)) : int'($urandom_range(0, 140));
      ny = $urandom_range(0, 140);
      ch = 1'($urandom_range(0, 1));
      drain(cx, cy, 2, -1, ch, nx, ny);
      if (!ch) begin
        idle_chk("rand idle");
        start(nx, ny);
      end
      cx = nx;
      cy = ny;
    end
    drain(cx, cy, 0, -1, 0, 0, 0);
    idle_chk("rand end");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
